// File: rtl/sid_pkg.sv
// Shared SID types: chip model, register/sample widths and the per-voice snapshot
// handed from sid_core to the voice stage.
package sid;

    typedef enum logic {
        MOS6581 = 1'b0,
        MOS8580 = 1'b1
    } model_e;

    typedef logic [7:0]         reg8_t;
    typedef logic signed [21:0] s22_t;

    // wave_sel bit order is {noise, pulse, saw, tri}
    typedef struct packed {
        logic [23:0] acc;
        logic [11:0] noise;
        logic [11:0] pw;
        logic [3:0]  wave_sel;
        logic        test;
        logic        ring_mod;
        logic        ring_msb;
        logic [7:0]  env;
    } voice_i_t;

endpackage

// File: rtl/sid_waveform.sv
// Combinational SID waveform generator: builds tri/saw/pulse/noise from the
// upper accumulator bits and ANDs together whichever are selected.
module sid_waveform (
    input  logic [11:0] acc_hi,
    input  logic [11:0] noise,
    input  logic [11:0] pw,
    input  logic [3:0]  wave_sel,
    input  logic        test,
    input  logic        ring_mod,
    input  logic        ring_msb,
    output logic [11:0] wave
);

    logic        msb;
    logic [11:0] tri_w;
    logic [11:0] saw_w;
    logic [11:0] pulse_w;

    always_comb begin
        msb     = acc_hi[11] ^ (ring_mod & ring_msb);
        tri_w   = msb ? {~acc_hi[10:0], 1'b0} : {acc_hi[10:0], 1'b0};
        saw_w   = acc_hi;
        pulse_w = (test || (acc_hi >= pw)) ? '1 : '0;

        // Combined waveforms are the AND of every selected source
        wave = '1;
        if (wave_sel[0]) wave = wave & tri_w;
        if (wave_sel[1]) wave = wave & saw_w;
        if (wave_sel[2]) wave = wave & pulse_w;
        if (wave_sel[3]) wave = wave & noise;
        if (wave_sel == 4'b0000) wave = '0;
    end

endmodule

// File: rtl/sid_voice_unit.sv
// Time-multiplexed SID voice stage: waveform, DC-zero removal and envelope
// scaling, registered once to give voice_o and the OSC3 readback with 1-cycle latency.
module sid_voice_unit
    import sid::*;
#(
    parameter logic [11:0] ZERO_6581 = 12'h380,
    parameter logic [11:0] ZERO_8580 = 12'h800
) (
    input  logic     clk,
    input  logic     rst_n,
    input  model_e   model,
    input  voice_i_t voice_i,
    output s22_t     voice_o,
    output reg8_t    osc_o
);

    logic [11:0]        wave;
    logic [11:0]        zero;
    logic signed [12:0] diff;
    s22_t               diff_x;
    s22_t               env_x;
    s22_t               sample;
    logic               unused_acc_lo;

    assign unused_acc_lo = ^voice_i.acc[11:0];

    sid_waveform u_waveform (
        .acc_hi   (voice_i.acc[23:12]),
        .noise    (voice_i.noise),
        .pw       (voice_i.pw),
        .wave_sel (voice_i.wave_sel),
        .test     (voice_i.test),
        .ring_mod (voice_i.ring_mod),
        .ring_msb (voice_i.ring_msb),
        .wave     (wave)
    );

    // Worst-case magnitudes stay inside 22 bits, so the product needs no saturation
    always_comb begin
        zero   = (model == MOS6581) ? ZERO_6581 : ZERO_8580;
        diff   = $signed({1'b0, wave}) - $signed({1'b0, zero});
        diff_x = {{9{diff[12]}}, diff};
        env_x  = {14'b0, voice_i.env};
        sample = diff_x * env_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voice_o <= '0;
            osc_o   <= '0;
        end else begin
            voice_o <= sample;
            osc_o   <= wave[11:4];
        end
    end

endmodule

// File: tb/tb_sid_voice_unit.sv
// Self-checking bench for sid_voice_unit: directed waveform cases, a back-to-back
// stream with a mid-stream reset, and random voices against an arithmetic model.
module tb_sid_voice_unit;
    import sid::*;

    logic     clk;
    logic     rst_n;
    model_e   model;
    voice_i_t voice_i;
    s22_t     voice_o;
    reg8_t    osc_o;

    int n_chk;
    int n_fail;

    sid_voice_unit #(
        .ZERO_6581 (12'h380),
        .ZERO_8580 (12'h800)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .model   (model),
        .voice_i (voice_i),
        .voice_o (voice_o),
        .osc_o   (osc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference waveform computed from the field definitions with integer arithmetic
    function automatic int ref_wave(input voice_i_t v);
        int saw, base, tri_v, pulse, msb, w;
        saw   = int'(v.acc >> 12);
        base  = int'(v.acc >> 11) & 'hFFE;
        msb   = int'(v.acc[23] ^ (v.ring_mod & v.ring_msb));
        tri_v = (msb != 0) ? ('hFFE - base) : base;
        pulse = (v.test || saw >= int'(v.pw)) ? 'hFFF : 0;
        if (v.wave_sel == 4'b0000) return 0;
        w = 'hFFF;
        if (v.wave_sel[0]) w = w & tri_v;
        if (v.wave_sel[1]) w = w & saw;
        if (v.wave_sel[2]) w = w & pulse;
        if (v.wave_sel[3]) w = w & int'(v.noise);
        return w;
    endfunction

    function automatic int ref_voice(input voice_i_t v, input model_e m);
        int zero;
        zero = (m == MOS6581) ? 'h380 : 'h800;
        return (ref_wave(v) - zero) * int'(v.env);
    endfunction

    function automatic voice_i_t rand_voice();
        voice_i_t v;
        v.acc      = 24'($urandom);
        v.noise    = 12'($urandom);
        v.pw       = 12'($urandom);
        v.wave_sel = 4'($urandom);
        v.test     = ($urandom_range(0, 7) == 0);
        v.ring_mod = 1'($urandom);
        v.ring_msb = 1'($urandom);
        v.env      = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
        return v;
    endfunction

    // Apply a voice, clock once, then compare both outputs against the model
    task automatic step(input string tag, input voice_i_t v, input model_e m);
        voice_i = v;
        model   = m;
        @(posedge clk);
        #1;
        check({tag, "_voice"}, int'(voice_o), ref_voice(v, m));
        check({tag, "_osc"}, int'(osc_o), ref_wave(v) >> 4);
    endtask

    voice_i_t v;
    voice_i_t stream[6];

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        model   = MOS8580;
        voice_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_voice", int'(voice_o), 0);
        check("reset_osc", int'(osc_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sawtooth at midscale and full scale on both models
        v = '0; v.wave_sel = 4'b0010; v.env = 8'hFF; v.acc = 24'h800000;
        step("saw_mid", v, MOS8580);
        check("saw_mid_v_const", int'(voice_o), 0);
        check("saw_mid_o_const", int'(osc_o), 'h80);
        v.acc = 24'hFFF000;
        step("saw_full8580", v, MOS8580);
        check("saw_full8580_const", int'(voice_o), 521985);
        check("saw_full_osc_const", int'(osc_o), 'hFF);
        step("saw_full6581", v, MOS6581);
        check("saw_full6581_const", int'(voice_o), 815745);
        v.acc = 24'h000000;
        step("saw_zero8580", v, MOS8580);
        check("saw_min_const", int'(voice_o), -522240);

        // Pulse threshold and test bit
        v = '0; v.wave_sel = 4'b0100; v.env = 8'h80; v.pw = 12'h800;
        v.acc = 24'h900000;
        step("pulse_hi", v, MOS6581);
        check("pulse_hi_const", int'(osc_o), 'hFF);
        v.acc = 24'h700000;
        step("pulse_lo", v, MOS6581);
        check("pulse_lo_const", int'(osc_o), 'h00);
        v.acc = 24'h800000;
        step("pulse_eq", v, MOS8580);
        check("pulse_eq_const", int'(osc_o), 'hFF);
        v.acc = 24'h700000; v.test = 1'b1;
        step("pulse_test", v, MOS6581);
        check("pulse_test_const", int'(osc_o), 'hFF);

        // Triangle plain and ring-modulated
        v = '0; v.wave_sel = 4'b0001; v.env = 8'h40; v.acc = 24'h400000;
        step("tri", v, MOS8580);
        check("tri_const", int'(osc_o), 'h80);
        v.ring_mod = 1'b1; v.ring_msb = 1'b1;
        step("tri_ring", v, MOS8580);
        check("tri_ring_const", int'(osc_o), 'h7F);

        // Noise alone, no waveform, zero envelope
        v = '0; v.wave_sel = 4'b1000; v.noise = 12'hA5C; v.env = 8'h00;
        step("noise_env0", v, MOS6581);
        check("env0_const", int'(voice_o), 0);
        check("noise_osc_const", int'(osc_o), 'hA5);
        v.wave_sel = 4'b0000; v.env = 8'hFF; v.acc = 24'hFFFFFF;
        step("none", v, MOS6581);
        check("none_const", int'(voice_o), -(12'h380 * 255));

        // Back-to-back stream with reset asserted in the middle
        for (int i = 0; i < 6; i++) stream[i] = rand_voice();
        for (int i = 0; i < 3; i++) step($sformatf("stream%0d", i), stream[i], model_e'(i % 2));
        voice_i = stream[3];
        rst_n = 1'b0;
        #1;
        check("midrst_voice_async", int'(voice_o), 0);
        check("midrst_osc_async", int'(osc_o), 0);
        @(posedge clk);
        #1;
        check("midrst_voice_held", int'(voice_o), 0);
        check("midrst_osc_held", int'(osc_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 3; i < 6; i++) step($sformatf("stream%0d", i), stream[i], model_e'(i % 2));

        // Random voices, random model
        for (int i = 0; i < 300; i++) begin
            step("rand", rand_voice(), model_e'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
